// File: rtl/issue_controller.sv
// Multi-lane decode/issue controller: per-lane decode, in-order issue with structural
// hazard checks (memory port, multiplier, HI/LO busy), and a registered control stage.
module issue_controller #(
  parameter int unsigned LANES    = 2,
  parameter int unsigned MULT_LAT = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [LANES-1:0]     in_valid,
  input  logic [6*LANES-1:0]   op,
  input  logic [6*LANES-1:0]   func,
  input  logic [LANES-1:0]     equal,
  input  logic                 hold,
  output logic [2:0]           issue_count,
  output logic                 stall,
  output logic                 mult_busy,
  output logic [LANES-1:0]     issue_valid,
  output logic [LANES-1:0]     memwrite,
  output logic [LANES-1:0]     regwrite,
  output logic [LANES-1:0]     memtoreg,
  output logic [LANES-1:0]     regdst,
  output logic [LANES-1:0]     alusrc,
  output logic [LANES-1:0]     se_ze,
  output logic [LANES-1:0]     branch,
  output logic [LANES-1:0]     start_mult,
  output logic [LANES-1:0]     mult_sign,
  output logic [4*LANES-1:0]   alu_op,
  output logic [2*LANES-1:0]   out_sel,
  output logic [LANES-1:0]     ill_op,
  output logic [1:0]           pcsrc
);

  localparam int unsigned CW = $clog2(MULT_LAT + 1);

  typedef struct packed {
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
    logic       regdst;
    logic       alusrc;
    logic       se_ze;
    logic       branch;
    logic       start_mult;
    logic       mult_sign;
    logic [3:0] alu_op;
    logic [1:0] out_sel;
    logic       ill_op;
    logic       is_mem;
    logic       is_mulunit;
    logic       is_beq;
    logic       is_bne;
    logic       is_j;
  } dec_t;

  // Single-lane decoder; unknown encodings decode to an all-zero nop with ill_op set.
  function automatic dec_t decode(input logic [5:0] o, input logic [5:0] f);
    dec_t d;
    d = '0;
    case (o)
      6'h00: begin
        d.regwrite = 1'b1;
        d.regdst   = 1'b1;
        case (f)
          6'h20, 6'h21: d.alu_op = 4'b0100;
          6'h22, 6'h23: d.alu_op = 4'b1100;
          6'h24:        d.alu_op = 4'b0000;
          6'h25:        d.alu_op = 4'b0001;
          6'h26:        d.alu_op = 4'b0010;
          6'h27:        d.alu_op = 4'b0011;
          6'h2a:        d.alu_op = 4'b1101;
          6'h2b:        d.alu_op = 4'b0110;
          6'h18, 6'h19: begin
            d.regwrite   = 1'b0;
            d.regdst     = 1'b0;
            d.start_mult = 1'b1;
            d.mult_sign  = (f == 6'h18);
            d.is_mulunit = 1'b1;
          end
          6'h10: begin d.out_sel = 2'b11; d.is_mulunit = 1'b1; end
          6'h12: begin d.out_sel = 2'b10; d.is_mulunit = 1'b1; end
          default: begin d = '0; d.ill_op = 1'b1; end
        endcase
      end
      6'h08, 6'h09: begin d.regwrite = 1'b1; d.alusrc = 1'b1; d.se_ze = 1'b1; d.alu_op = 4'b0100; end
      6'h0a:        begin d.regwrite = 1'b1; d.alusrc = 1'b1; d.se_ze = 1'b1; d.alu_op = 4'b1101; end
      6'h0b:        begin d.regwrite = 1'b1; d.alusrc = 1'b1; d.se_ze = 1'b1; d.alu_op = 4'b0110; end
      6'h0c:        begin d.regwrite = 1'b1; d.alusrc = 1'b1; d.alu_op = 4'b0000; end
      6'h0d:        begin d.regwrite = 1'b1; d.alusrc = 1'b1; d.alu_op = 4'b0001; end
      6'h0e:        begin d.regwrite = 1'b1; d.alusrc = 1'b1; d.alu_op = 4'b0010; end
      6'h0f:        begin d.regwrite = 1'b1; d.alusrc = 1'b1; d.out_sel = 2'b01; end
      6'h23: begin
        d.regwrite = 1'b1; d.alusrc = 1'b1; d.memtoreg = 1'b1; d.se_ze = 1'b1;
        d.alu_op = 4'b0100; d.is_mem = 1'b1;
      end
      6'h2b: begin
        d.memwrite = 1'b1; d.alusrc = 1'b1; d.se_ze = 1'b1;
        d.alu_op = 4'b0100; d.is_mem = 1'b1;
      end
      6'h04:   begin d.branch = 1'b1; d.se_ze = 1'b1; d.is_beq = 1'b1; end
      6'h05:   begin d.branch = 1'b1; d.se_ze = 1'b1; d.is_bne = 1'b1; end
      6'h02:   d.is_j = 1'b1;
      default: d.ill_op = 1'b1;
    endcase
    return d;
  endfunction

  dec_t           dec [LANES];
  logic [CW-1:0]  mult_cnt;
  logic [LANES-1:0] issued;
  logic [2:0]     cnt;
  logic [2:0]     vcnt;
  logic           chain;
  logic           mem_seen;
  logic           mul_seen;
  logic           ctl_seen;
  logic           mult_load;
  logic [1:0]     pc_next;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      dec[k] = decode(op[6*k +: 6], func[6*k +: 6]);
    end
  end

  // In-order issue walk; once a lane is blocked every younger lane is blocked too.
  always_comb begin
    issued    = '0;
    cnt       = 3'd0;
    vcnt      = 3'd0;
    chain     = 1'b1;
    mem_seen  = 1'b0;
    mul_seen  = 1'b0;
    ctl_seen  = 1'b0;
    mult_load = 1'b0;
    pc_next   = 2'b00;
    for (int k = 0; k < LANES; k++) begin
      vcnt  = vcnt + 3'(in_valid[k]);
      chain = chain & in_valid[k] & ~hold & ~(dec[k].is_mem & mem_seen)
            & ~(dec[k].is_mulunit & (mult_busy | mul_seen)) & ~ctl_seen;
      issued[k] = chain;
      if (chain) begin
        cnt       = cnt + 3'd1;
        mem_seen  = mem_seen | dec[k].is_mem;
        mul_seen  = mul_seen | dec[k].start_mult;
        ctl_seen  = ctl_seen | dec[k].is_beq | dec[k].is_bne | dec[k].is_j;
        mult_load = mult_load | dec[k].start_mult;
        if ((dec[k].is_beq & equal[k]) | (dec[k].is_bne & ~equal[k])) pc_next = 2'b01;
        if (dec[k].is_j) pc_next = 2'b10;
      end
    end
  end

  assign issue_count = cnt;
  assign stall       = (|in_valid) & (cnt < vcnt);
  assign mult_busy   = (mult_cnt != '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mult_cnt    <= '0;
      issue_valid <= '0;
      memwrite    <= '0;
      regwrite    <= '0;
      memtoreg    <= '0;
      regdst      <= '0;
      alusrc      <= '0;
      se_ze       <= '0;
      branch      <= '0;
      start_mult  <= '0;
      mult_sign   <= '0;
      alu_op      <= '0;
      out_sel     <= '0;
      ill_op      <= '0;
      pcsrc       <= 2'b00;
    end else begin
      if (mult_load)               mult_cnt <= CW'(MULT_LAT);
      else if (mult_cnt != '0)     mult_cnt <= mult_cnt - CW'(1);
      for (int k = 0; k < LANES; k++) begin
        issue_valid[k]    <= issued[k];
        memwrite[k]       <= issued[k] & dec[k].memwrite;
        regwrite[k]       <= issued[k] & dec[k].regwrite;
        memtoreg[k]       <= issued[k] & dec[k].memtoreg;
        regdst[k]         <= issued[k] & dec[k].regdst;
        alusrc[k]         <= issued[k] & dec[k].alusrc;
        se_ze[k]          <= issued[k] & dec[k].se_ze;
        branch[k]         <= issued[k] & dec[k].branch;
        start_mult[k]     <= issued[k] & dec[k].start_mult;
        mult_sign[k]      <= issued[k] & dec[k].mult_sign;
        ill_op[k]         <= issued[k] & dec[k].ill_op;
        alu_op[4*k +: 4]  <= issued[k] ? dec[k].alu_op  : 4'b0000;
        out_sel[2*k +: 2] <= issued[k] ? dec[k].out_sel : 2'b00;
      end
      pcsrc <= pc_next;
    end
  end

endmodule

// File: tb/tb_issue_controller.sv
// Scoreboard bench for issue_controller: an instruction-stream model predicts each cycle's
// issue result and registered controls; a negedge monitor compares against the DUT.
module tb_issue_controller;
  localparam int unsigned L  = 2;
  localparam int unsigned ML = 4;

  localparam int C_PLAIN = 0, C_MEM = 1, C_MULT = 2, C_MFX = 3, C_BEQ = 4, C_BNE = 5, C_J = 6;
  localparam logic [9:0] F_MW = 10'h200, F_RW = 10'h100, F_MTR = 10'h080, F_RD = 10'h040,
                         F_AS = 10'h020, F_SE = 10'h010, F_BR = 10'h008, F_SM = 10'h004,
                         F_MS = 10'h002, F_ILL = 10'h001;

  typedef struct {
    logic [5:0] op;
    logic [5:0] func;
    logic [3:0] alu;
    logic [1:0] osel;
    logic [9:0] fl;
    int         cls;
  } ins_t;

  typedef struct packed {
    logic [L-1:0]   iv, mw, rw, mtr, rd, as, se, br, sm, ms, ill;
    logic [4*L-1:0] alu;
    logic [2*L-1:0] os;
    logic [1:0]     pc;
  } regs_t;

  typedef struct {
    int    cnt;
    bit    stl;
    bit    mb;
    regs_t r;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic [L-1:0] in_valid, equal;
  logic [6*L-1:0] op, func;
  logic hold;
  logic [2:0] issue_count;
  logic stall, mult_busy;
  logic [L-1:0] issue_valid, memwrite, regwrite, memtoreg, regdst, alusrc, se_ze, branch,
                start_mult, mult_sign, ill_op;
  logic [4*L-1:0] alu_op;
  logic [2*L-1:0] out_sel;
  logic [1:0] pcsrc;

  issue_controller #(.LANES(L), .MULT_LAT(ML)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .op(op), .func(func), .equal(equal),
    .hold(hold), .issue_count(issue_count), .stall(stall), .mult_busy(mult_busy),
    .issue_valid(issue_valid), .memwrite(memwrite), .regwrite(regwrite), .memtoreg(memtoreg),
    .regdst(regdst), .alusrc(alusrc), .se_ze(se_ze), .branch(branch), .start_mult(start_mult),
    .mult_sign(mult_sign), .alu_op(alu_op), .out_sel(out_sel), .ill_op(ill_op), .pcsrc(pcsrc)
  );

  always #5 clk = ~clk;

  ins_t  tbl [29];
  int    prog[$];
  exp_t  sb[$];
  regs_t cur_regs;
  int    mcnt;
  int    n_chk;
  int    n_fail;

  function automatic ins_t mk(logic [5:0] o, logic [5:0] f, logic [3:0] a, logic [1:0] s,
                              logic [9:0] fl, int c);
    ins_t r;
    r.op = o; r.func = f; r.alu = a; r.osel = s; r.fl = fl; r.cls = c;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle of the reference model: present the head of the stream, decide issue, queue expectations.
  task automatic step(input bit rst, input bit rnd);
    int nv, n;
    bit h, mem_s, mul_s, ctl_s, mload, blocked;
    logic [L-1:0] eq;
    logic [6*L-1:0] o, f;
    regs_t nx;
    exp_t e;
    ins_t t;
    nv = (prog.size() < L) ? prog.size() : L;
    if (rnd && nv > 0 && $urandom_range(0, 3) == 0) nv = $urandom_range(0, nv);
    if (rst) nv = 0;
    h  = rnd && ($urandom_range(0, 6) == 0);
    eq = L'($urandom);
    o  = (6*L)'($urandom);
    f  = (6*L)'($urandom);
    for (int k = 0; k < nv; k++) begin
      o[6*k +: 6] = tbl[prog[k]].op;
      f[6*k +: 6] = tbl[prog[k]].func;
    end
    reset_n  = ~rst;
    in_valid = L'((1 << nv) - 1);
    op = o; func = f; equal = eq; hold = h;

    nx = '0; n = 0; mem_s = 0; mul_s = 0; ctl_s = 0; mload = 0;
    for (int k = 0; k < nv; k++) begin
      t = tbl[prog[k]];
      blocked = h || ctl_s || (t.cls == C_MEM && mem_s)
             || ((t.cls == C_MULT || t.cls == C_MFX) && (mcnt != 0 || mul_s));
      if (blocked) break;
      n++;
      nx.iv[k] = 1'b1;
      {nx.mw[k], nx.rw[k], nx.mtr[k], nx.rd[k], nx.as[k], nx.se[k], nx.br[k], nx.sm[k],
       nx.ms[k], nx.ill[k]} = t.fl;
      nx.alu[4*k +: 4] = t.alu;
      nx.os[2*k +: 2]  = t.osel;
      if (t.cls == C_MEM)  mem_s = 1;
      if (t.cls == C_MULT) begin mul_s = 1; mload = 1; end
      if (t.cls == C_BEQ) begin ctl_s = 1; if (eq[k])  nx.pc = 2'b01; end
      if (t.cls == C_BNE) begin ctl_s = 1; if (!eq[k]) nx.pc = 2'b01; end
      if (t.cls == C_J)   begin ctl_s = 1; nx.pc = 2'b10; end
    end
    e.cnt = n;
    e.stl = (n < nv);
    e.mb  = (mcnt != 0);
    e.r   = cur_regs;
    sb.push_back(e);

    if (rst) begin
      cur_regs = '0;
      mcnt = 0;
    end else begin
      cur_regs = nx;
      if (mload) mcnt = ML;
      else if (mcnt > 0) mcnt--;
      for (int k = 0; k < n; k++) void'(prog.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: the DUT presents a result every cycle; compare it against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("issue_count", 32'(issue_count), 32'(e.cnt));
      chk("stall",       32'(stall),       32'(e.stl));
      chk("mult_busy",   32'(mult_busy),   32'(e.mb));
      chk("issue_valid", 32'(issue_valid), 32'(e.r.iv));
      chk("memwrite",    32'(memwrite),    32'(e.r.mw));
      chk("regwrite",    32'(regwrite),    32'(e.r.rw));
      chk("memtoreg",    32'(memtoreg),    32'(e.r.mtr));
      chk("regdst",      32'(regdst),      32'(e.r.rd));
      chk("alusrc",      32'(alusrc),      32'(e.r.as));
      chk("se_ze",       32'(se_ze),       32'(e.r.se));
      chk("branch",      32'(branch),      32'(e.r.br));
      chk("start_mult",  32'(start_mult),  32'(e.r.sm));
      chk("mult_sign",   32'(mult_sign),   32'(e.r.ms));
      chk("ill_op",      32'(ill_op),      32'(e.r.ill));
      chk("alu_op",      32'(alu_op),      32'(e.r.alu));
      chk("out_sel",     32'(out_sel),     32'(e.r.os));
      chk("pcsrc",       32'(pcsrc),       32'(e.r.pc));
    end
  end

  initial begin
    // Instruction table: add..sltu, mult/multu, mfhi/mflo, I-type, lw/sw, beq/bne/j, illegal
    tbl[0]  = mk(6'h00, 6'h20, 4'b0100, 2'b00, F_RW | F_RD, C_PLAIN);
    tbl[1]  = mk(6'h00, 6'h21, 4'b0100, 2'b00, F_RW | F_RD, C_PLAIN);
    tbl[2]  = mk(6'h00, 6'h22, 4'b1100, 2'b00, F_RW | F_RD, C_PLAIN);
    tbl[3]  = mk(6'h00, 6'h23, 4'b1100, 2'b00, F_RW | F_RD, C_PLAIN);
    tbl[4]  = mk(6'h00, 6'h24, 4'b0000, 2'b00, F_RW | F_RD, C_PLAIN);
    tbl[5]  = mk(6'h00, 6'h25, 4'b0001, 2'b00, F_RW | F_RD, C_PLAIN);
    tbl[6]  = mk(6'h00, 6'h26, 4'b0010, 2'b00, F_RW | F_RD, C_PLAIN);
    tbl[7]  = mk(6'h00, 6'h27, 4'b0011, 2'b00, F_RW | F_RD, C_PLAIN);
    tbl[8]  = mk(6'h00, 6'h2a, 4'b1101, 2'b00, F_RW | F_RD, C_PLAIN);
    tbl[9]  = mk(6'h00, 6'h2b, 4'b0110, 2'b00, F_RW | F_RD, C_PLAIN);
    tbl[10] = mk(6'h00, 6'h18, 4'b0000, 2'b00, F_SM | F_MS, C_MULT);
    tbl[11] = mk(6'h00, 6'h19, 4'b0000, 2'b00, F_SM, C_MULT);
    tbl[12] = mk(6'h00, 6'h10, 4'b0000, 2'b11, F_RW | F_RD, C_MFX);
    tbl[13] = mk(6'h00, 6'h12, 4'b0000, 2'b10, F_RW | F_RD, C_MFX);
    tbl[14] = mk(6'h08, 6'h00, 4'b0100, 2'b00, F_RW | F_AS | F_SE, C_PLAIN);
    tbl[15] = mk(6'h09, 6'h00, 4'b0100, 2'b00, F_RW | F_AS | F_SE, C_PLAIN);
    tbl[16] = mk(6'h0a, 6'h00, 4'b1101, 2'b00, F_RW | F_AS | F_SE, C_PLAIN);
    tbl[17] = mk(6'h0b, 6'h00, 4'b0110, 2'b00, F_RW | F_AS | F_SE, C_PLAIN);
    tbl[18] = mk(6'h0c, 6'h00, 4'b0000, 2'b00, F_RW | F_AS, C_PLAIN);
    tbl[19] = mk(6'h0d, 6'h00, 4'b0001, 2'b00, F_RW | F_AS, C_PLAIN);
    tbl[20] = mk(6'h0e, 6'h00, 4'b0010, 2'b00, F_RW | F_AS, C_PLAIN);
    tbl[21] = mk(6'h0f, 6'h00, 4'b0000, 2'b01, F_RW | F_AS, C_PLAIN);
    tbl[22] = mk(6'h23, 6'h00, 4'b0100, 2'b00, F_RW | F_AS | F_MTR | F_SE, C_MEM);
    tbl[23] = mk(6'h2b, 6'h00, 4'b0100, 2'b00, F_MW | F_AS | F_SE, C_MEM);
    tbl[24] = mk(6'h04, 6'h00, 4'b0000, 2'b00, F_BR | F_SE, C_BEQ);
    tbl[25] = mk(6'h05, 6'h00, 4'b0000, 2'b00, F_BR | F_SE, C_BNE);
    tbl[26] = mk(6'h02, 6'h00, 4'b0000, 2'b00, 10'h000, C_J);
    tbl[27] = mk(6'h3f, 6'h00, 4'b0000, 2'b00, F_ILL, C_PLAIN);
    tbl[28] = mk(6'h00, 6'h01, 4'b0000, 2'b00, F_ILL, C_PLAIN);

    n_chk = 0; n_fail = 0; mcnt = 0; cur_regs = '0;
    reset_n = 1'b0; in_valid = '0; op = '0; func = '0; equal = '0; hold = 1'b0;
    @(posedge clk);
    #1;
    step(1, 0);
    step(1, 0);

    // Directed stream: add/ori pair, lw/sw split, mult then mfhi wait, branches, illegal, jump
    prog = '{0, 19, 22, 23, 10, 12, 24, 0, 25, 0, 27, 0, 26, 5, 28, 11, 13};
    for (int c = 0; c < 60 && prog.size() != 0; c++) step(0, 0);

    // Reset while the multiplier is busy, then HI/LO read must issue immediately
    prog.push_back(10);
    step(0, 0);
    step(0, 0);
    step(1, 0);
    prog.push_back(12);
    step(0, 0);
    step(0, 0);

    // Randomized stream with holds, partial presentation and rare resets
    for (int c = 0; c < 800; c++) begin
      while (prog.size() < 2 * L) prog.push_back($urandom_range(0, 28));
      step($urandom_range(0, 149) == 0, 1);
    end
    prog.delete();
    step(0, 0);
    step(0, 0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
